// File: rtl/md_unit_if.sv
// md_unit_if: operand/request and result bundle between the core
// controller (master) and the multiply/divide unit (slave).
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU engine writing the HI/LO pair,
// plus direct MTHI/MTLO writes. Signed operations run on magnitudes and
// the sign is restored in a single fix-up cycle at the end.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  md_unit_if.slave md
);

  localparam int CW = $clog2(ITER);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  // Control / operand registers
  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_prep;     // first CALC cycle loads the magnitude
  logic               r_is_div;
  logic               r_neg_a;    // signed op with negative A
  logic               r_neg_b;    // signed op with negative B
  logic               r_div0;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;      // product, or {remainder, quotient}

  // Architectural outputs
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  // Datapath wires
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_a_mag = r_neg_a ? (~r_a + ONE_W) : r_a;
  assign w_b_mag = r_neg_b ? (~r_b + ONE_W) : r_b;

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, w_b_mag} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff     = w_rem_sh - {1'b0, w_b_mag};
    if (w_diff[WIDTH]) begin
      w_div_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
    if (r_is_div) begin
      w_step = w_div_next;
    end else begin
      w_step = w_mul_next;
    end
  end

  // Sign restoration and final HI/LO selection, including divide-by-zero
  always_comb begin
    w_prod_fix = (r_neg_a ^ r_neg_b) ? (~r_acc + ONE_2W) : r_acc;
    w_quo_fix  = (r_neg_a ^ r_neg_b) ? (~r_acc[WIDTH-1:0] + ONE_W)
                                     : r_acc[WIDTH-1:0];
    w_rem_fix  = r_neg_a ? (~r_acc[2*WIDTH-1:WIDTH] + ONE_W)
                         : r_acc[2*WIDTH-1:WIDTH];
    if (r_div0) begin
      w_fix_hi = r_a;
      w_fix_lo = {WIDTH{1'b1}};
    end else if (r_is_div) begin
      w_fix_hi = w_rem_fix;
      w_fix_lo = w_quo_fix;
    end else begin
      w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and HI/LO register updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_prep   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_div0   <= 1'b0;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (md.Start) begin
            case (md.Op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_a      <= md.A;
                r_b      <= md.B;
                r_is_div <= md.Op[1];
                r_neg_a  <= ~md.Op[0] & md.A[WIDTH-1];
                r_neg_b  <= ~md.Op[0] & md.B[WIDTH-1];
                r_div0   <= md.Op[1] & (md.B == {WIDTH{1'b0}});
                r_cnt    <= {CW{1'b0}};
                r_prep   <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= ST_CALC;
              end
              OP_MTHI: r_hi <= md.A;
              OP_MTLO: r_lo <= md.A;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (r_prep) begin
            r_prep <= 1'b0;
            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
          end else begin
            r_acc <= w_step;
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        ST_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign md.Busy = r_busy;
  assign md.Done = r_done;
  assign md.HI   = r_hi;
  assign md.LO   = r_lo;

endmodule
